// File: rtl/alu_seq_pipe_if.sv
// Valid/ready operand and result bundle for alu_seq_pipe.
// The master drives operands and out_ready. The slave (the ALU) drives the result, the flags and in_ready.
interface alu_seq_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALUCntl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUout;
   logic             C;
   logic             N;
   logic             Z;
   logic             V;

   modport master (
      output in_valid, A, B, ALUCntl, out_ready,
      input  in_ready, out_valid, ALUout, C, N, Z, V
   );

   modport slave (
      input  in_valid, A, B, ALUCntl, out_ready,
      output in_ready, out_valid, ALUout, C, N, Z, V
   );
endinterface

// File: rtl/alu_seq_pipe.sv
// Registered ALU sitting between register read and writeback.
// Single-cycle ops have a latency of 1. MULU is an iterative shift-add multiply taking WIDTH cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | accepts ops; single-cycle results load on the accept edge
// ST_MUL  | shift-add multiply, one multiplier bit per cycle, no accept
module alu_seq_pipe #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   alu_seq_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADDU = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_MULU = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SUBU = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_XOR2 = 4'b1001;
   localparam logic [3:0] OP_ADD  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_SLL  = 4'b1101;
   localparam logic [3:0] OP_SUB  = 4'b1110;
   localparam logic [3:0] OP_SLTU = 4'b1111;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic [0:0]         r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_alu_out;
   logic               r_c;
   logic               r_n;
   logic               r_z;
   logic               r_v;
   logic [2*WIDTH-1:0] r_ma;
   logic [WIDTH-1:0]   r_mb;
   logic [2*WIDTH-1:0] r_acc;
   logic [SHW-1:0]     r_cnt;

   logic               w_in_ready;
   logic               w_accept;
   logic [SHW-1:0]     w_shamt;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH:0]     w_sll_ext;
   logic [WIDTH:0]     w_srl_ext;
   logic [WIDTH:0]     w_sra_ext;
   logic               w_add_ovf;
   logic               w_sub_ovf;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic               w_n_clr;
   logic               w_n;
   logic               w_z;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_in_ready = (r_state == ST_IDLE) & (~r_out_valid | bus.out_ready);
   assign w_accept   = bus.in_valid & w_in_ready;

   assign w_shamt   = bus.B[SHW-1:0];
   assign w_sum     = {1'b0, bus.A} + {1'b0, bus.B};
   assign w_diff    = {1'b0, bus.A} - {1'b0, bus.B};
   assign w_add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) & (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
   assign w_sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) & (w_diff[WIDTH-1] != bus.A[WIDTH-1]);

   // One guard bit on the exit side of each shift catches the last bit shifted out.
   // That guard bit is naturally 0 when shamt is 0.
   assign w_sll_ext = {1'b0, bus.A} << w_shamt;
   assign w_srl_ext = {bus.A, 1'b0} >> w_shamt;
   assign w_sra_ext = $unsigned($signed({bus.A, 1'b0}) >>> w_shamt);

   always_comb begin
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      w_n_clr = 1'b0;
      case (bus.ALUCntl)
         OP_AND:  w_res = bus.A & bus.B;
         OP_OR:   w_res = bus.A | bus.B;
         OP_XOR,
         OP_XOR2: w_res = bus.A ^ bus.B;
         OP_NOR:  w_res = ~(bus.A | bus.B);
         OP_NOT:  w_res = ~bus.A;
         OP_ADDU: begin
            w_res   = w_sum[WIDTH-1:0];
            w_c     = w_sum[WIDTH];
            w_v     = w_sum[WIDTH];
            w_n_clr = 1'b1;
         end
         OP_SUBU: begin
            w_res   = w_diff[WIDTH-1:0];
            w_c     = w_diff[WIDTH];
            w_v     = w_diff[WIDTH];
            w_n_clr = 1'b1;
         end
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_add_ovf;
         end
         OP_SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = w_sub_ovf;
         end
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         OP_SLL: begin
            w_res = w_sll_ext[WIDTH-1:0];
            w_c   = w_sll_ext[WIDTH];
         end
         OP_SRL: begin
            w_res = w_srl_ext[WIDTH:1];
            w_c   = w_srl_ext[0];
         end
         OP_SRA: begin
            w_res = w_sra_ext[WIDTH:1];
            w_c   = w_sra_ext[0];
         end
         default: w_res = '0;
      endcase
   end

   assign w_n = w_n_clr ? 1'b0 : w_res[WIDTH-1];
   assign w_z = (w_res == '0);

   assign w_acc_next = r_acc + (r_mb[0] ? r_ma : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_alu_out   <= '0;
         r_c         <= 1'b0;
         r_n         <= 1'b0;
         r_z         <= 1'b1;
         r_v         <= 1'b0;
         r_ma        <= '0;
         r_mb        <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (bus.ALUCntl == OP_MULU) begin
                     r_state     <= ST_MUL;
                     r_ma        <= {{WIDTH{1'b0}}, bus.A};
                     r_mb        <= bus.B;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_alu_out   <= w_res;
                     r_c         <= w_c;
                     r_n         <= w_n;
                     r_z         <= w_z;
                     r_v         <= w_v;
                     r_out_valid <= 1'b1;
                  end
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               r_acc <= w_acc_next;
               r_ma  <= r_ma << 1;
               r_mb  <= r_mb >> 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b1;
                  r_alu_out   <= w_acc_next[WIDTH-1:0];
                  r_c         <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_v         <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_n         <= w_acc_next[WIDTH-1];
                  r_z         <= (w_acc_next[WIDTH-1:0] == '0);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.ALUout    = r_alu_out;
   assign bus.C         = r_c;
   assign bus.N         = r_n;
   assign bus.Z         = r_z;
   assign bus.V         = r_v;
endmodule

// File: tb/tb_alu_seq_pipe.sv
// Bench for alu_seq_pipe: a vector table of single-cycle ops plus hand-written multi-cycle sequences.
// A 32-bit and an 8-bit instance are checked; results of the 32-bit instance go through an expected-value queue.
module tb_alu_seq_pipe;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   alu_seq_pipe_if #(.WIDTH(32)) bus ();
   alu_seq_pipe_if #(.WIDTH(8))  bus8 ();

   alu_seq_pipe #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   alu_seq_pipe #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c;
      logic        n;
      logic        z;
      logic        v;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        n;
      logic        z;
      logic        v;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   vec_t vecs[19];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%h want=%h", name, act, exp);
   endtask

   task automatic push(input logic [31:0] res, input logic c, input logic n, input logic z, input logic v);
      q.push_back('{res: res, c: c, n: n, z: z, v: v});
   endtask

   // Drive one op and hold it until it is accepted; returns #1 after the accept edge.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      bus.ALUCntl  = op;
      bus.A        = a;
      bus.B        = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_in_time", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      check("drain_empty", 64'(q.size()), 64'd0);
      @(posedge clk);
      #1;
      check("idle_after_drain", 64'(bus.out_valid), 64'd0);
   endtask

   // Every result the consumer takes is compared with the head of the expected-value queue.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output got=%h want=none", bus.ALUout);
         end else begin
            mon_e = q.pop_front();
            check("result", 64'({bus.ALUout, bus.C, bus.N, bus.Z, bus.V}), 64'(mon_e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic busy_ok;
      logic quiet_ok;
      int   lat;

      vecs[0]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{4'b0011, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{4'b1001, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{4'b0111, 32'h0000_FFFF, 32'h0000_1234, 32'hFFFF_0000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{4'b1010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{4'b1110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{4'b1101, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{4'b1000, 32'h8000_0010, 32'h0000_0005, 32'h0400_0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{4'b1011, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{4'b1101, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{4'b1011, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{4'b1110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.ALUCntl   = '0;
      bus.out_ready = 1'b1;
      bus8.in_valid  = 1'b0;
      bus8.A         = '0;
      bus8.B         = '0;
      bus8.ALUCntl   = '0;
      bus8.out_ready = 1'b1;

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_aluout", 64'(bus.ALUout), 64'd0);
      check("rst_cnzv", 64'({bus.C, bus.N, bus.Z, bus.V}), 64'b0010);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst8_valid_z", 64'({bus8.out_valid, bus8.Z}), 64'b01);

      // ADD overflow, one-cycle latency
      push(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      send(4'b1010, 32'h7FFF_FFFF, 32'h0000_0001);
      check("add_latency1", 64'(bus.out_valid), 64'd1);
      drain();

      // Back-to-back table: one accept per cycle
      for (int i = 0; i < 19; i++) begin
         @(posedge clk);
         #1;
         bus.ALUCntl  = vecs[i].op;
         bus.A        = vecs[i].a;
         bus.B        = vecs[i].b;
         bus.in_valid = 1'b1;
         push(vecs[i].res, vecs[i].c, vecs[i].n, vecs[i].z, vecs[i].v);
         @(negedge clk);
         check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      drain();

      // Hold under backpressure, then a reload on the same edge the old result is taken
      bus.out_ready = 1'b0;
      push(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
      send(4'b0110, 32'h0000_0003, 32'h0000_0005);
      bus.ALUCntl  = 4'b0011;
      bus.A        = 32'h0000_000F;
      bus.B        = 32'h0000_00FF;
      bus.in_valid = 1'b1;
      push(32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_stable",
               64'({bus.out_valid, bus.in_ready, bus.ALUout, bus.C, bus.N, bus.Z, bus.V}),
               64'({1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1}));
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("reload_keeps_valid", 64'({bus.out_valid, bus.ALUout}), 64'({1'b1, 32'h0000_00F0}));
      drain();

      // MULU with busy window and toggling inputs
      push(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      bus.ALUCntl  = 4'b0100;
      bus.A        = 32'h0001_0000;
      bus.B        = 32'h0001_0000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("mul_accept_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      busy_ok = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         bus.A       = $urandom;
         bus.B       = $urandom;
         bus.ALUCntl = 4'($urandom_range(0, 15));
         @(negedge clk);
         if (bus.in_ready || bus.out_valid) busy_ok = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("mul_busy_32", 64'(busy_ok), 64'd1);
      check("mul_latency33", 64'(bus.out_valid), 64'd1);
      drain();

      push(32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
      send(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();
      push(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      send(4'b0100, 32'h8000_0000, 32'h0000_0001);
      drain();

      // Reset in the middle of a multiply
      send(4'b0100, 32'h0000_0003, 32'h0000_0005);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_state",
            64'({bus.out_valid, bus.in_ready, bus.ALUout, bus.Z}),
            64'({1'b0, 1'b1, 32'h0, 1'b1}));
      quiet_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) quiet_ok = 1'b0;
      end
      check("abort_quiet", 64'(quiet_ok), 64'd1);
      push(32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0);
      send(4'b0100, 32'h0000_0003, 32'h0000_0005);
      drain();

      // 8-bit instance: ADDU wrap and multiply latency
      @(posedge clk);
      #1;
      bus8.ALUCntl  = 4'b0010;
      bus8.A        = 8'hFF;
      bus8.B        = 8'h01;
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      check("w8_addu_wrap",
            64'({bus8.out_valid, bus8.ALUout, bus8.C, bus8.N, bus8.Z, bus8.V}),
            64'({1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1}));
      @(posedge clk);
      #1;
      bus8.ALUCntl  = 4'b0100;
      bus8.A        = 8'd15;
      bus8.B        = 8'd17;
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      lat = 1;
      while (!bus8.out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("w8_mul_latency", 64'(lat), 64'd9);
      check("w8_mul_result",
            64'({bus8.ALUout, bus8.C, bus8.N, bus8.Z, bus8.V}),
            64'({8'hFF, 1'b0, 1'b1, 1'b0, 1'b0}));

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
